// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundling memory, flag, stall and decode-side signals.
interface fetch_unit_if;
    logic [15:0] ins;
    logic        flag_z;
    logic        flag_n;
    logic        stall;
    logic [7:0]  addr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ras_overflow;
    logic        ras_underflow;
    modport master (input ins, flag_z, flag_n, stall,
                    output addr, ir, ir_pc, ir_valid, ras_overflow, ras_underflow);
    modport slave  (output ins, flag_z, flag_n, stall,
                    input addr, ir, ir_pc, ir_valid, ras_overflow, ras_underflow);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch stage resolving br, brz, brn, br.sub and return with a return-address stack.
module fetch_unit #(
    parameter int         RAS_DEPTH = 4,
    parameter logic [7:0] RESET_PC  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    localparam int SPW = $clog2(RAS_DEPTH + 1);
    localparam int IW  = $clog2(RAS_DEPTH);
    logic [7:0]     pc_q, pc_d, ir_pc_q, seq, tgt;
    logic [15:0]    ir_q;
    logic           ir_valid_q, ovf_q, ovf_d, unf_q, unf_d, push, full, empty, taken;
    logic [SPW-1:0] sp_q, sp_d;
    logic [3:0]     opc;
    logic [1:0]     cc;
    logic [IW-1:0]  wr_idx, rd_idx;
    logic [7:0]     ras_q [RAS_DEPTH];
    assign bus.addr          = pc_q;
    assign bus.ir            = ir_q;
    assign bus.ir_pc         = ir_pc_q;
    assign bus.ir_valid      = ir_valid_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
    always_comb begin
        opc    = bus.ins[7:4];
        cc     = bus.ins[3:2];
        tgt    = bus.ins[15:8];
        seq    = pc_q + 8'd2;
        full   = sp_q == SPW'(RAS_DEPTH);
        empty  = sp_q == '0;
        wr_idx = IW'(sp_q);
        rd_idx = IW'(sp_q - SPW'(1));
        taken  = cc == 2'b00 ? bus.flag_z : cc == 2'b01 ? bus.flag_n : 1'b0;
        pc_d   = seq;
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push   = 1'b0;
        if (opc == 4'b1001) begin
            pc_d = tgt;
        end else if (opc == 4'b1010) begin
            pc_d = taken ? tgt : seq;
        end else if (opc == 4'b1011) begin
            pc_d  = tgt;
            push  = !full;
            sp_d  = full ? sp_q : sp_q + SPW'(1);
            ovf_d = ovf_q | full;
        end else if (opc == 4'b1100) begin
            // An empty-stack return falls through rather than jumping to garbage
            pc_d  = empty ? seq : ras_q[rd_idx];
            sp_d  = empty ? sp_q : sp_q - SPW'(1);
            unf_d = unf_q | empty;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            ir_valid_q <= !bus.stall;
            if (!bus.stall) begin
                pc_q    <= pc_d;
                ir_q    <= bus.ins;
                ir_pc_q <= pc_q;
                sp_q    <= sp_d;
                ovf_q   <= ovf_d;
                unf_q   <= unf_d;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst && !bus.stall && push) ras_q[wr_idx] <= seq;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and fetch stage sitting directly upstream of the instruction memory. It drives the 8-bit fetch address, captures the 16-bit instruction word into an instruction register for decode, and resolves all control flow itself: br, brz, brn, br.sub and return. A small return-address stack (RAS) supports subroutine calls.

Parameters:
RAS_DEPTH, 4, number of return-address stack entries (power of two, 2..16)
RESET_PC, 8'h00, fetch address loaded on reset

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous active-low reset
ins  in  16  instruction word from instruction memory: low byte at addr in [7:0], high byte at addr+1 in [15:8]
flag_z  in  1  architectural zero flag from the ALU flag register
flag_n  in  1  architectural negative flag from the ALU flag register
stall  in  1  hold fetch; no state changes while high
addr  out  8  fetch address to instruction memory; equals the PC register
ir  out  16  registered instruction for decode
ir_pc  out  8  address that ir was fetched from
ir_valid  out  1  high for one cycle when ir holds a newly fetched instruction
ras_overflow  out  1  sticky; set when a call is made while the RAS is full
ras_underflow  out  1  sticky; set when a return is made while the RAS is empty

Behaviour:
- Reset (rst low, asynchronous, any time including mid-call): pc=RESET_PC, ir=16'h0000, ir_pc=0, ir_valid=0, RAS pointer=0, both sticky flags=0. RAS entry contents are don't-care.
- addr is driven combinationally from pc. Memory read is combinational, so ins is valid in the same cycle.
- Each posedge with stall=0:
  - ir<=ins, ir_pc<=pc, ir_valid<=1, pc<=next_pc.
  - Instruction throughput is 1 per cycle.
- Each posedge with stall=1: pc, ir, ir_pc, RAS and flags hold; ir_valid<=0.
- Decode for next_pc uses opc=ins[7:4], cc=ins[3:2] and tgt=ins[15:8]:
  - opc 1001 (br): next_pc=tgt.
  - opc 1010, cc=00 (brz): next_pc=tgt if flag_z, else pc+2.
  - opc 1010, cc=01 (brn): next_pc=tgt if flag_n, else pc+2.
  - opc 1010, cc=1x: reserved; never taken, next_pc=pc+2.
  - opc 1011 (br.sub): push pc+2 onto the RAS, then next_pc=tgt.
    - If the RAS is full: the push is dropped, ras_overflow<=1, and the jump is still taken.
  - opc 1100 (return): pop the RAS and set next_pc=popped value.
    - If the RAS is empty: ras_underflow<=1, next_pc=pc+2, pointer unchanged.
  - All other opcodes: next_pc=pc+2.
- Arithmetic: pc+2 is an 8-bit sum with wrap-around, so 8'hFE+2=8'h00. Targets are used verbatim; odd targets are legal and not checked.
- Flags are sampled in the same cycle as the branch word is on ins. Forwarding of flag updates from the instruction in ir is the decode/execute stage's job: that stage must assert stall for one cycle when needed.
- RAS: stack pointer sp ranges 0..RAS_DEPTH.
  - Push writes entry[sp] and increments sp.
  - Pop reads entry[sp-1] and decrements sp.
  - Full means sp==RAS_DEPTH; empty means sp==0.
- Sticky flags clear only on reset.

Test Plan:
1. Release reset with memory holding nops -> addr steps 00,02,04,06 on successive cycles; ir_valid goes high from the first posedge after reset; ir_pc lags addr by one cycle.
2. br 8'h10 at addr 8'h2E (ins=16'h1090) -> next addr 8'h10; ir=16'h1090; ir_pc=8'h2E.
3. brz 8'h24 at 8'h1E (ins=16'h24A0): with flag_z=1 -> next addr 8'h24; with flag_z=0 -> 8'h20. Also brn (16'h30A4) with flag_n=1 at 8'h2C -> next addr 8'h30.
4. br.sub 8'h34 at 8'h28, then return (16'h00C0) at 8'h40 -> addr sequence 28,34,...,40,2A; ras_overflow and ras_underflow stay 0.
5. With RAS_DEPTH=4, issue 5 nested calls then 5 returns -> ras_overflow=1 after the 5th call. Returns go to the 4th, 3rd, 2nd and 1st return addresses, then the 5th return sets ras_underflow=1 and falls through to pc+2.
6. Hold stall=1 for 3 cycles at addr 8'h10 -> addr stays 8'h10, ir unchanged, ir_valid=0. Pulse rst low mid-stall -> addr=00 and ir_valid=0 immediately (asynchronous). Separately, pc at 8'hFE with a nop -> next addr 8'h00.
